// File: rtl/inv_mix_columns_stage_pkg.sv
// Shared AES state types, GF(2^8) helpers and stage latency for the inverse MixColumns stage.
// The latency constant follows INV_MIX_SKID_EN.
package inv_mix_columns_stage_pkg;

    localparam int AES_ROW    = 4;
    localparam int AES_COLUMN = 4;

`ifdef INV_MIX_SKID_EN
    localparam int INV_MIX_LATENCY = 3;
`else
    localparam int INV_MIX_LATENCY = 2;
`endif

    // Column-major state: byte k = 4*col+row sits at bits [8k+7:8k]
    typedef logic [AES_ROW-1:0][7:0]      aes_column_t;
    typedef aes_column_t [AES_COLUMN-1:0] aes_matrix_t;

    typedef struct packed {
        logic [7:0] x8;
        logic [7:0] x4;
        logic [7:0] x2;
        logic [7:0] b;
    } byte_mults_t;

    typedef byte_mults_t [AES_ROW-1:0]   col_mults_t;
    typedef col_mults_t [AES_COLUMN-1:0] mults_matrix_t;

    function automatic logic [7:0] gf_xtime_f(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul_f(input logic [7:0] b, input logic [7:0] k);
        logic [7:0] acc;
        logic [7:0] p;
        acc = '0;
        p   = b;
        for (int i = 0; i < 8; i++) begin
            if (k[i]) acc = acc ^ p;
            p = gf_xtime_f(p);
        end
        return acc;
    endfunction

endpackage

// File: rtl/inv_mix_columns_stage_single_column.sv
// InvMixColumns for one column, built from precomputed x1/x2/x4/x8 multiples.
// Latency: combinational.
// Backpressure: none, pure datapath.
module inv_mix_columns_stage_single_column
    import inv_mix_columns_stage_pkg::*;
(
    input  col_mults_t  col_mul,
    output aes_column_t col_dat
);

    aes_column_t m9;
    aes_column_t mb;
    aes_column_t md;
    aes_column_t me;

    for (genvar r = 0; r < AES_ROW; r++) begin : g_row
        assign m9[r] = col_mul[r].x8 ^ col_mul[r].b;
        assign mb[r] = col_mul[r].x8 ^ col_mul[r].x2 ^ col_mul[r].b;
        assign md[r] = col_mul[r].x8 ^ col_mul[r].x4 ^ col_mul[r].b;
        assign me[r] = col_mul[r].x8 ^ col_mul[r].x4 ^ col_mul[r].x2;
    end

    assign col_dat[0] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
    assign col_dat[1] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
    assign col_dat[2] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
    assign col_dat[3] = mb[0] ^ md[1] ^ m9[2] ^ me[3];

endmodule

// File: rtl/inv_mix_columns_stage.sv
// AXI-Stream InvMixColumns stage (plain register slice when MIX_COLUMNS_EN=0).
// Latency: 2 cycles, 3 with INV_MIX_SKID_EN (2-entry skid in front, registered aes_in_tready).
// Backpressure: full valid/ready, both stages hold while aes_out_tready is low.
module inv_mix_columns_stage
    import inv_mix_columns_stage_pkg::*;
#(
    parameter bit MIX_COLUMNS_EN = 1'b1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [127:0] aes_in_tdata,
    input  logic         aes_in_tvalid,
    input  logic         aes_in_tlast,
    output logic         aes_in_tready,
    output logic [127:0] aes_out_tdata,
    output logic         aes_out_tvalid,
    output logic         aes_out_tlast,
    input  logic         aes_out_tready
);

    logic          stage_in_vld;
    logic          stage_in_rdy;
    logic          stage_in_last;
    aes_matrix_t   stage_in_dat;

`ifdef INV_MIX_SKID_EN
    logic [128:0]  skid_mem [2];
    logic [1:0]    skid_cnt;
    logic [1:0]    skid_cnt_nxt;
    logic          skid_wr_ptr;
    logic          skid_rd_ptr;
    logic          skid_full;
    logic          skid_push;
    logic          skid_pop;

    // Ready is the registered not-full bit: no path from aes_out_tready
    assign aes_in_tready = !skid_full;
    assign skid_push     = aes_in_tvalid && !skid_full;
    assign skid_pop      = stage_in_vld && stage_in_rdy;
    assign stage_in_vld  = (skid_cnt != 2'd0);
    assign {stage_in_last, stage_in_dat} = skid_mem[skid_rd_ptr];

    always_comb begin
        skid_cnt_nxt = skid_cnt;
        if (skid_push && !skid_pop)      skid_cnt_nxt = skid_cnt + 2'd1;
        else if (!skid_push && skid_pop) skid_cnt_nxt = skid_cnt - 2'd1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < 2; i++) skid_mem[i] <= '0;
            skid_cnt    <= '0;
            skid_wr_ptr <= 1'b0;
            skid_rd_ptr <= 1'b0;
            skid_full   <= 1'b0;
        end else begin
            if (skid_push) begin
                skid_mem[skid_wr_ptr] <= {aes_in_tlast, aes_in_tdata};
                skid_wr_ptr           <= !skid_wr_ptr;
            end
            if (skid_pop) skid_rd_ptr <= !skid_rd_ptr;
            skid_cnt  <= skid_cnt_nxt;
            skid_full <= (skid_cnt_nxt == 2'd2);
        end
    end
`else
    assign stage_in_vld  = aes_in_tvalid;
    assign stage_in_last = aes_in_tlast;
    assign stage_in_dat  = aes_in_tdata;
    assign aes_in_tready = stage_in_rdy;
`endif

    logic          s1_vld;
    logic          s1_last;
    mults_matrix_t s1_mul;
    logic          s2_vld;
    logic          s2_last;
    aes_matrix_t   s2_dat;
    mults_matrix_t in_mul;
    aes_matrix_t   mix_dat;
    logic          s1_load;
    logic          s2_load;

    assign s2_load      = !s2_vld || aes_out_tready;
    assign s1_load      = !s1_vld || s2_load;
    assign stage_in_rdy = s1_load;

    always_comb begin
        in_mul = '0;
        for (int c = 0; c < AES_COLUMN; c++) begin
            for (int r = 0; r < AES_ROW; r++) begin
                in_mul[c][r].b  = stage_in_dat[c][r];
                in_mul[c][r].x2 = gf_xtime_f(stage_in_dat[c][r]);
                in_mul[c][r].x4 = gf_xtime_f(gf_xtime_f(stage_in_dat[c][r]));
                in_mul[c][r].x8 = gf_xtime_f(gf_xtime_f(gf_xtime_f(stage_in_dat[c][r])));
            end
        end
    end

    for (genvar c = 0; c < AES_COLUMN; c++) begin : g_col
        if (MIX_COLUMNS_EN) begin : g_mix
            inv_mix_columns_stage_single_column u_col (
                .col_mul (s1_mul[c]),
                .col_dat (mix_dat[c])
            );
        end else begin : g_pass
            for (genvar r = 0; r < AES_ROW; r++) begin : g_row
                assign mix_dat[c][r] = s1_mul[c][r].b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1_vld  <= 1'b0;
            s1_last <= 1'b0;
            s1_mul  <= '0;
            s2_vld  <= 1'b0;
            s2_last <= 1'b0;
            s2_dat  <= '0;
        end else begin
            if (s1_load) begin
                s1_vld <= stage_in_vld;
                if (stage_in_vld) begin
                    s1_mul  <= in_mul;
                    s1_last <= stage_in_last;
                end
            end
            if (s2_load) begin
                s2_vld <= s1_vld;
                if (s1_vld) begin
                    s2_dat  <= mix_dat;
                    s2_last <= s1_last;
                end
            end
        end
    end

    assign aes_out_tvalid = s2_vld;
    assign aes_out_tdata  = s2_dat;
    assign aes_out_tlast  = s2_last;

endmodule
